pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_seq_if.sv | 30 +++
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: next-PC source selector and
// the priority decode that picks it from the control inputs.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      PC_SRC_HOLD,
      PC_SRC_RET,
      PC_SRC_TARGET,
      PC_SRC_BRANCH,
      PC_SRC_SKIP,
      PC_SRC_INC
   } pc_src_e;

   // Strict priority: stall > call&ret > ret > call/jump > branch > skip > increment.
   // Without a RAS, ret is ignored and call degenerates to jump.
   function automatic pc_src_e decode_next(input logic stall, input logic jump,
                                           input logic call, input logic ret,
                                           input logic branch_taken, input logic skip,
                                           input logic ras_en, input logic ras_empty);
      if (stall)                     return PC_SRC_HOLD;
      if (ras_en && ret && !call)    return ras_empty ? PC_SRC_INC : PC_SRC_RET;
      if (call || jump)              return PC_SRC_TARGET;
      if (branch_taken)              return PC_SRC_BRANCH;
      if (skip)                      return PC_SRC_SKIP;
      return PC_SRC_INC;
   endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control/decode-to-sequencer bus: redirect controls in, registered pc and RAS status out.
interface pc_seq_if #(
   parameter int PC_W      = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic            stall;
   logic            jump;
   logic            call;
   logic            ret;
   logic            branch_taken;
   logic            skip;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] branch_offset;
   logic [PC_W-1:0] pc;
   logic [CNT_W-1:0] ras_count;
   logic            ras_ovf;
   logic            ras_unf;

   modport master (
      output stall, jump, call, ret, branch_taken, skip, target, branch_offset,
      input  pc, ras_count, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, jump, call, ret, branch_taken, skip, target, branch_offset,
      output pc, ras_count, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push (overwrites oldest when full), pop and
// in-place replace of the top entry, with registered overflow/underflow pulses.
module pc_ras #(
   parameter  int PC_W      = 32,
   parameter  int RAS_DEPTH = 4,
   localparam int CNT_W     = $clog2(RAS_DEPTH + 1),
   localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             replace,
   input  logic [PC_W-1:0]  din,
   output logic [PC_W-1:0]  top,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             unf
);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(RAS_DEPTH - 1);

   logic [PC_W-1:0]  mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic             full;
   logic             empty;

   assign full    = (count == CNT_W'(RAS_DEPTH));
   assign empty   = (count == '0);
   assign ptr_inc = (ptr == LAST) ? '0 : ptr + PTR_W'(1);
   assign ptr_dec = (ptr == '0) ? LAST : ptr - PTR_W'(1);
   assign top     = mem[ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         ovf <= push && full;
         unf <= pop && empty;
         if (push) begin
            ptr <= ptr_inc;
            if (!full) count <= count + CNT_W'(1);
         end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CNT_W'(1);
         end
      end
   end

   // NOTE: storage is deliberately not reset; count==0 makes stale entries
   // unreachable, and a reset-free array maps onto plain RAM cells.
   always_ff @(posedge clock) begin
      if (push)         mem[ptr_inc] <= din;
      else if (replace) mem[ptr]     <= din;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Word-addressed program-counter sequencer with prioritised redirects.
// Define PC_RAS_EN to build the return-address stack (call/ret support).
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int          PC_W      = 32,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned SKIP_STEP = 2,
   parameter int          RAS_DEPTH = 4
) (
   input logic      clock,
   input logic      reset,
   pc_seq_if.slave  bus
);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] ret_addr;
   logic [PC_W-1:0] ras_top;
   logic            ras_en;
   logic            ras_empty;
   pc_src_e         src;

   assign ret_addr = pc_q + PC_W'(1);

`ifdef PC_RAS_EN
   logic [CNT_W-1:0] ras_count;
   logic             ras_ovf;
   logic             ras_unf;
   logic             live;
   logic             do_push;
   logic             do_pop;
   logic             do_replace;

   assign ras_en    = 1'b1;
   assign ras_empty = (ras_count == '0);
   assign live      = !bus.stall;
   // call&ret on an empty stack is a plain call, so it pushes instead.
   assign do_replace = live && bus.call && bus.ret && !ras_empty;
   assign do_push    = live && bus.call && !do_replace;
   assign do_pop     = live && bus.ret && !bus.call;

   pc_ras #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock   (clock),
      .reset   (reset),
      .push    (do_push),
      .pop     (do_pop),
      .replace (do_replace),
      .din     (ret_addr),
      .top     (ras_top),
      .count   (ras_count),
      .ovf     (ras_ovf),
      .unf     (ras_unf)
   );

   assign bus.ras_count = ras_count;
   assign bus.ras_ovf   = ras_ovf;
   assign bus.ras_unf   = ras_unf;
`else
   assign ras_en        = 1'b0;
   assign ras_empty     = 1'b1;
   assign ras_top       = '0;
   assign bus.ras_count = '0;
   assign bus.ras_ovf   = 1'b0;
   assign bus.ras_unf   = 1'b0;
`endif

   always_comb begin
      // NOTE: defaults first so no path through the block leaves pc_d
      // unassigned, which would otherwise infer a latch.
      pc_d = pc_q;
      src  = decode_next(bus.stall, bus.jump, bus.call, bus.ret,
                         bus.branch_taken, bus.skip, ras_en, ras_empty);
      case (src)
         PC_SRC_HOLD:   pc_d = pc_q;
         PC_SRC_RET:    pc_d = ras_top;
         PC_SRC_TARGET: pc_d = bus.target;
         PC_SRC_BRANCH: pc_d = pc_q + bus.branch_offset;
         PC_SRC_SKIP:   pc_d = pc_q + PC_W'(SKIP_STEP);
         PC_SRC_INC:    pc_d = ret_addr;
         default:       pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) pc_q <= PC_W'(RESET_PC);
      else       pc_q <= pc_d;
   end

   assign bus.pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, multi-cycle RAS
// sequences, and randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pc_seq_if #(.PC_W(32), .RAS_DEPTH(DEPTH)) bus ();

   pc_sequencer #(
      .PC_W      (32),
      .RESET_PC  (0),
      .SKIP_STEP (2),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: pc plus an unbounded-then-trimmed queue as the stack.
   logic [31:0] m_pc;
   logic [31:0] ras [$];
   logic        m_ovf;
   logic        m_unf;

   typedef struct {
      logic        rst, s, j, c, r, b, k;
      logic [31:0] tgt, off;
      logic [31:0] exp_pc;
      int          exp_cnt;
      logic        exp_unf;
   } vec_t;

   vec_t tab [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic j, input logic c, input logic r,
                        input logic b, input logic k, input logic [31:0] tgt,
                        input logic [31:0] off);
      bus.stall = s; bus.jump = j; bus.call = c; bus.ret = r;
      bus.branch_taken = b; bus.skip = k; bus.target = tgt; bus.branch_offset = off;
   endtask

   task automatic model_push(input logic [31:0] v);
      ras.push_back(v);
      if (ras.size() > DEPTH) begin
         void'(ras.pop_front());
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_step();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (reset) begin
         m_pc = 32'd0;
         ras.delete();
      end else if (bus.stall) begin
         m_pc = m_pc;
      end else if (RAS_EN && bus.call && bus.ret) begin
         if (ras.size() == 0) model_push(m_pc + 32'd1);
         else ras[ras.size() - 1] = m_pc + 32'd1;
         m_pc = bus.target;
      end else if (RAS_EN && bus.ret) begin
         if (ras.size() > 0) m_pc = ras.pop_back();
         else begin
            m_pc  = m_pc + 32'd1;
            m_unf = 1'b1;
         end
      end else if (bus.call || bus.jump) begin
         if (RAS_EN && bus.call) model_push(m_pc + 32'd1);
         m_pc = bus.target;
      end else if (bus.branch_taken) m_pc = m_pc + bus.branch_offset;
      else if (bus.skip)             m_pc = m_pc + 32'd2;
      else                           m_pc = m_pc + 32'd1;
   endtask

   // Advance one edge and compare every output against the model.
   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      check("m_pc",  bus.pc, m_pc);
      check("m_cnt", 32'(bus.ras_count), 32'(ras.size()));
      check("m_ovf", 32'(bus.ras_ovf), 32'(m_ovf));
      check("m_unf", 32'(bus.ras_unf), 32'(m_unf));
   endtask

   function automatic vec_t mk(input logic rst, input logic s, input logic j,
                               input logic c, input logic r, input logic b,
                               input logic k, input logic [31:0] tgt,
                               input logic [31:0] off, input logic [31:0] exp_pc,
                               input int exp_cnt, input logic exp_unf);
      vec_t v;
      v.rst = rst; v.s = s; v.j = j; v.c = c; v.r = r; v.b = b; v.k = k;
      v.tgt = tgt; v.off = off; v.exp_pc = exp_pc; v.exp_cnt = exp_cnt; v.exp_unf = exp_unf;
      return v;
   endfunction

   initial begin
      logic [31:0] ret_pcs [5];

      drive(0, 0, 0, 0, 0, 0, 0, 0);

      //          rst s  j  c  r  b  k  target        offset        pc                    cnt          unf
      tab[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd0,                0,           0);
      tab[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd1,                0,           0);
      tab[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd2,                0,           0);
      tab[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd3,                0,           0);
      tab[4]  = mk(0, 0, 1, 0, 0, 0, 0, 32'd10,       32'd0,        32'd10,               0,           0);
      tab[5]  = mk(0, 0, 0, 0, 0, 1, 0, 32'd0,        32'hFFFFFFFC, 32'd6,                0,           0);
      tab[6]  = mk(0, 0, 0, 0, 0, 0, 1, 32'd0,        32'd0,        32'd8,                0,           0);
      tab[7]  = mk(0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF,         0,           0);
      tab[8]  = mk(0, 0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd0,                0,           0);
      tab[9]  = mk(0, 1, 1, 0, 0, 0, 0, 32'd77,       32'd0,        32'd0,                0,           0);
      tab[10] = mk(0, 0, 1, 0, 0, 1, 1, 32'd50,       32'd3,        32'd50,               0,           0);
      tab[11] = mk(0, 0, 1, 0, 0, 0, 0, 32'd5,        32'd0,        32'd5,                0,           0);
      tab[12] = mk(0, 0, 0, 1, 0, 0, 0, 32'd100,      32'd0,        32'd100,              RAS_EN ? 1 : 0, 0);
      tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd101,              RAS_EN ? 1 : 0, 0);
      tab[14] = mk(0, 0, 0, 0, 1, 0, 0, 32'd0,        32'd0,        RAS_EN ? 32'd6 : 32'd102, 0,       0);
      tab[15] = mk(0, 0, 0, 0, 1, 0, 1, 32'd0,        32'd0,        RAS_EN ? 32'd7 : 32'd104, 0,       RAS_EN);

      for (int i = 0; i < 16; i++) begin
         reset = tab[i].rst;
         drive(tab[i].s, tab[i].j, tab[i].c, tab[i].r, tab[i].b, tab[i].k, tab[i].tgt, tab[i].off);
         tick();
         check($sformatf("vec%0d_pc", i), bus.pc, tab[i].exp_pc);
         check($sformatf("vec%0d_cnt", i), 32'(bus.ras_count), 32'(tab[i].exp_cnt));
         check($sformatf("vec%0d_unf", i), 32'(bus.ras_unf), 32'(tab[i].exp_unf));
      end

      // RAS overflow: five calls from 1, 11, 21, 31, 41 then five returns.
      reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
      reset = 1'b0;
      drive(0, 1, 0, 0, 0, 0, 32'd1, 0); tick();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 1, 0, 0, 0, 32'(10 * i + 1), 0); tick();
         check("ovf_quiet", 32'(bus.ras_ovf), 32'd0);
      end
      drive(0, 0, 1, 0, 0, 0, 32'd200, 0); tick();
      check("ovf_pulse", 32'(bus.ras_ovf), 32'(RAS_EN));
      check("ovf_cnt", 32'(bus.ras_count), RAS_EN ? 32'd4 : 32'd0);
      ret_pcs = '{32'd42, 32'd32, 32'd22, 32'd12, 32'd13};
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
         check($sformatf("ret%0d_pc", i), bus.pc, RAS_EN ? ret_pcs[i] : 32'(201 + i));
         check($sformatf("ret%0d_unf", i), 32'(bus.ras_unf), 32'(RAS_EN && i == 4));
         check($sformatf("ret%0d_ovf", i), 32'(bus.ras_ovf), 32'd0);
      end

      // call+ret replaces the top entry and leaves the count alone.
      reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
      reset = 1'b0;
      drive(0, 1, 0, 0, 0, 0, 32'd6, 0);  tick();
      drive(0, 0, 1, 0, 0, 0, 32'd30, 0); tick();
      drive(0, 0, 1, 1, 0, 0, 32'd80, 0); tick();
      check("cr_pc", bus.pc, 32'd80);
      check("cr_cnt", 32'(bus.ras_count), RAS_EN ? 32'd1 : 32'd0);
      drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
      check("cr_ret_pc", bus.pc, RAS_EN ? 32'd31 : 32'd81);

      // Reset mid-stack discards entries; next ret underflows.
      drive(0, 0, 1, 0, 0, 0, 32'd20, 0); tick();
      drive(0, 0, 1, 0, 0, 0, 32'd40, 0); tick();
      reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
      check("rst_pc", bus.pc, 32'd0);
      check("rst_cnt", 32'(bus.ras_count), 32'd0);
      reset = 1'b0;
      drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
      check("rst_ret_pc", bus.pc, 32'd1);
      check("rst_ret_unf", 32'(bus.ras_unf), 32'(RAS_EN));

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0 ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom,
               $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 16)) - 32'd8);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
